// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: resolves a conditional branch in three states and issues a one-cycle PC load
module branch_pc_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       cond_code,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] offset,
    output logic             busy,
    output logic             con_out,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic             done,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

    state_t           state, state_nx;
    logic [1:0]       cc_q;
    logic [WIDTH-1:0] bus_q, pc_q, off_q;
    logic             taken;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: a request walks IDLE -> EVAL -> UPDATE -> IDLE; start is ignored outside IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? EVAL : IDLE;
            EVAL:    state_nx = UPDATE;
            default: state_nx = IDLE;
        endcase
    end

    // Condition evaluation on the latched operands; brpl treats zero as non-negative
    always_comb begin
        taken = 1'b0;
        case (cc_q)
            2'b00:   taken = (bus_q == '0);
            2'b01:   taken = (bus_q != '0);
            2'b10:   taken = ~bus_q[WIDTH-1];
            default: taken = bus_q[WIDTH-1];
        endcase
    end

    // Operand latch so input changes after the start edge cannot disturb the result
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cc_q  <= '0;
            bus_q <= '0;
            pc_q  <= '0;
            off_q <= '0;
        end else if (state == IDLE && start) begin
            cc_q  <= cond_code;
            bus_q <= bus_in;
            pc_q  <= pc_in;
            off_q <= offset;
        end
    end

    // Registered outputs: condition in EVAL, PC/pulses/counter in UPDATE
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            con_out   <= 1'b0;
            pc_load   <= 1'b0;
            done      <= 1'b0;
            pc_next   <= RESET_PC;
            taken_cnt <= '0;
        end else begin
            done    <= (state == UPDATE);
            pc_load <= (state == UPDATE) && con_out;
            if (state == EVAL) con_out <= taken;
            if (state == UPDATE) begin
                pc_next <= con_out ? pc_q + off_q : pc_q;
                if (con_out && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule
